// File: rtl/seg_msg_scroller_pkg.sv
// seg_msg_scroller_pkg: shared segment codes, mode and state encodings
package seg_msg_scroller_pkg;
  localparam logic [7:0] CH_BLANK = 8'hFF;
  localparam logic [7:0] CH_H = 8'h89;
  localparam logic [7:0] CH_E = 8'h86;
  localparam logic [7:0] CH_L = 8'hC7;
  localparam logic [7:0] CH_O = 8'hC0;
  typedef enum logic {MODE_STEP = 1'b0, MODE_SCROLL = 1'b1} mode_e;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
endpackage

// File: rtl/seg_tick_div.sv
// seg_tick_div: prescaler counting 0..DIV-1 with clear and step on the last count
module seg_tick_div #(
  parameter int DIV = 4
) (
  input  logic ck,
  input  logic rs,
  input  logic clr,
  output logic step
);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] cnt;
  assign step = cnt == CW'(DIV - 1);
  always_ff @(posedge ck or negedge rs)
    if (!rs) cnt <= '0;
    else cnt <= (clr || step) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/seg_msg_scroller.sv
// seg_msg_scroller: plays a message onto a 7-segment window in step or scroll mode
module seg_msg_scroller
  import seg_msg_scroller_pkg::*;
#(
  parameter int MSG_LEN = 5,
  parameter int N_DIG = 4,
  parameter int DIV = 4,
  parameter logic [7:0] BLANK = 8'hFF,
  localparam int PW = $clog2(MSG_LEN + N_DIG + 1)
) (
  input  logic                 ck,
  input  logic                 rs,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 mode,
  input  logic                 loop,
  input  logic [8*MSG_LEN-1:0] msg,
  output logic [8*N_DIG-1:0]   win,
  output logic [PW-1:0]        pos,
  output logic                 busy,
  output logic                 done
);
  state_e state, nxt_state;
  mode_e mode_q, src_mode;
  logic loop_q, idle, step, nxt_done;
  logic [8*MSG_LEN-1:0] msg_q, src_msg;
  logic [PW-1:0] nxt_pos, last;
  logic [8*N_DIG-1:0] nxt_win;
  function automatic logic [8*N_DIG-1:0] frame(input int f, input logic [8*MSG_LEN-1:0] m, input mode_e md);
    frame = {N_DIG{BLANK}};
    for (int d = 0; d < N_DIG; d++)
      if (md == MODE_SCROLL) begin
        if (f + d >= N_DIG && f + d < N_DIG + MSG_LEN) frame[8*d+:8] = m[8*(f+d-N_DIG)+:8];
      end else if (d == 0 && f >= 1) frame[7:0] = m[8*(f-1)+:8];
  endfunction
  seg_tick_div #(.DIV(DIV)) u_div (.ck(ck), .rs(rs), .clr(idle || stop), .step(step));
  assign busy = state == RUN;
  always_comb begin
    idle = state == IDLE;
    src_msg = idle ? msg : msg_q;
    src_mode = idle ? mode_e'(mode) : mode_q;
    last = PW'(src_mode == MODE_SCROLL ? MSG_LEN + N_DIG : MSG_LEN);
    nxt_state = state;
    nxt_pos = pos;
    nxt_done = 1'b0;
    if (stop) begin
      nxt_state = IDLE;
      nxt_pos = '0;
    end else if (idle) begin
      nxt_state = start ? RUN : IDLE;
      nxt_pos = '0;
    end else if (step) begin
      nxt_pos = pos == last ? '0 : pos + 1'b1;
      nxt_state = (pos == last && !loop_q) ? IDLE : RUN;
      nxt_done = pos == last && !loop_q;
    end
    nxt_win = nxt_state == RUN ? frame(int'(nxt_pos), src_msg, src_mode) : {N_DIG{BLANK}};
  end
  always_ff @(posedge ck or negedge rs)
    if (!rs) begin
      state <= IDLE;
      pos <= '0;
      win <= {N_DIG{BLANK}};
      done <= 1'b0;
      msg_q <= '0;
      mode_q <= MODE_STEP;
      loop_q <= 1'b0;
    end else begin
      state <= nxt_state;
      pos <= nxt_pos;
      win <= nxt_win;
      done <= nxt_done;
      if (idle && start && !stop) begin
        msg_q <= msg;
        mode_q <= mode_e'(mode);
        loop_q <= loop;
      end
    end
endmodule

// File: tb/tb_seg_msg_scroller.sv
// tb_seg_msg_scroller: random and directed play checked against a tape-based reference model
module tb_seg_msg_scroller;
  import seg_msg_scroller_pkg::*;
  localparam int L = 5, N = 4, D = 2;
  localparam int PW = $clog2(L + N + 1);
  logic ck = 0, rs = 1, start = 0, stop = 0, mode = 0, loop = 0;
  logic [8*L-1:0] msg = '0;
  logic [8*N-1:0] win;
  logic [PW-1:0] pos;
  logic busy, done;
  logic [8*L-1:0] hello;
  int total = 0, bad = 0;
  bit m_busy = 0, m_mode = 0, m_loop = 0, m_done = 0;
  int k = 0;
  logic [7:0] m_chr[L];
  always #5 ck = ~ck;
  seg_msg_scroller #(.MSG_LEN(L), .N_DIG(N), .DIV(D), .BLANK(CH_BLANK)) dut (
    .ck(ck), .rs(rs), .start(start), .stop(stop), .mode(mode), .loop(loop),
    .msg(msg), .win(win), .pos(pos), .busy(busy), .done(done));
  function automatic int nframes();
    return m_mode ? L + N + 1 : L + 1;
  endfunction
  function automatic logic [31:0] exp_win();
    logic [7:0] tape[$];
    logic [31:0] w = {N{CH_BLANK}};
    int f = k / D;
    if (!m_busy) return w;
    if (m_mode) begin
      repeat (N) tape.push_back(CH_BLANK);
      for (int i = 0; i < L; i++) tape.push_back(m_chr[i]);
      repeat (N) tape.push_back(CH_BLANK);
      for (int d = 0; d < N; d++) w[8*d+:8] = tape[f+d];
    end else begin
      tape.push_back(CH_BLANK);
      for (int i = 0; i < L; i++) tape.push_back(m_chr[i]);
      w[7:0] = tape[f];
    end
    return w;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string ph);
    chk({ph, "_win"}, win, exp_win());
    chk({ph, "_pos"}, 32'(pos), m_busy ? 32'(k / D) : 32'd0);
    chk({ph, "_busy"}, 32'(busy), 32'(m_busy));
    chk({ph, "_done"}, 32'(done), 32'(m_done));
  endtask
  task automatic model(input bit st, input bit sp);
    m_done = 0;
    if (!m_busy) begin
      if (st && !sp) begin
        m_busy = 1;
        k = 0;
        m_mode = mode;
        m_loop = loop;
        for (int i = 0; i < L; i++) m_chr[i] = msg[8*i+:8];
      end
    end else if (sp) begin
      m_busy = 0;
      k = 0;
    end else begin
      k++;
      if (k >= nframes() * D) begin
        k = 0;
        if (!m_loop) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  endtask
  task automatic cyc(input string ph, input bit st = 0, input bit sp = 0);
    start = st;
    stop = sp;
    @(posedge ck);
    model(st, sp);
    #1;
    start = 0;
    stop = 0;
    check_all(ph);
  endtask
  task automatic async_reset(input string ph);
    #3 rs = 0;
    #1;
    m_busy = 0;
    m_done = 0;
    k = 0;
    check_all(ph);
    #2 rs = 1;
  endtask
  initial begin
    hello = {CH_O, CH_L, CH_L, CH_E, CH_H};
    #1 rs = 0;
    #1 check_all("reset");
    #10 rs = 1;
    msg = hello; mode = MODE_STEP; loop = 0;
    cyc("step_start", 1, 0);
    repeat (14) cyc("step_once");
    mode = MODE_SCROLL;
    cyc("scroll_start", 1, 0);
    repeat (22) cyc("scroll_once");
    mode = MODE_STEP; loop = 1;
    cyc("loop_start", 1, 0);
    repeat (30) cyc("step_loop");
    cyc("loop_stop", 0, 1);
    repeat (3) cyc("after_stop");
    mode = MODE_SCROLL; loop = 0;
    cyc("busy_start", 1, 0);
    repeat (5) cyc("busy_run");
    mode = MODE_STEP; loop = 1; msg = '1;
    cyc("start_while_busy", 1, 0);
    repeat (20) cyc("busy_run2");
    cyc("start_stop_idle", 1, 1);
    repeat (2) cyc("idle_hold");
    msg = hello; mode = MODE_SCROLL;
    cyc("rst_start", 1, 0);
    repeat (11) cyc("rst_run");
    async_reset("async_reset");
    repeat (2) cyc("post_reset");
    cyc("replay_start", 1, 0);
    repeat (22) cyc("replay");
    for (int it = 0; it < 25; it++) begin
      msg = {$urandom, $urandom};
      mode = 1'($urandom_range(0, 1));
      loop = 1'($urandom_range(0, 1));
      for (int c = 0; c < 40; c++) begin
        if (c > 0 && $urandom_range(0, 3) == 0) begin
          msg = {$urandom, $urandom};
          mode = 1'($urandom_range(0, 1));
          loop = 1'($urandom_range(0, 1));
        end
        if (c == 20 && it % 5 == 0) async_reset("rand_reset");
        cyc("rand", c == 0 || $urandom_range(0, 15) == 0, $urandom_range(0, 29) == 0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
